// File: rtl/mem_responder.sv
// Memory-side responder: turns 32-bit RAM requests into two 16-bit beats on an
// external asynchronous SRAM and returns the word with a one-cycle ready pulse.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [15:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic        ram_cack,
    output logic        ram_busy,
    output logic        ram_data_ready,
    output logic [31:0] ram_data,
    output logic [16:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_oe,
    output logic        sram_we
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    // Holds the write hi halfword during writes, the captured lo halfword during reads.
    logic [15:0]      hold, hold_n;
    logic             cack_n, busy_n, ready_n, dq_oe_n, oe_n, we_n;
    logic [31:0]      data_n;
    logic [16:0]      addr_n;
    logic [15:0]      dq_out_n;
    logic             beat_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            hold           <= '0;
            ram_cack       <= 1'b0;
            ram_busy       <= 1'b0;
            ram_data_ready <= 1'b0;
            ram_data       <= '0;
            sram_addr      <= '0;
            sram_dq_out    <= '0;
            sram_dq_oe     <= 1'b0;
            sram_oe        <= 1'b0;
            sram_we        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            hold           <= hold_n;
            ram_cack       <= cack_n;
            ram_busy       <= busy_n;
            ram_data_ready <= ready_n;
            ram_data       <= data_n;
            sram_addr      <= addr_n;
            sram_dq_out    <= dq_out_n;
            sram_dq_oe     <= dq_oe_n;
            sram_oe        <= oe_n;
            sram_we        <= we_n;
        end
    end

    // Next-state and next-output logic; every output above is registered from here.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hold_n   = hold;
        cack_n   = 1'b0;
        busy_n   = ram_busy;
        ready_n  = 1'b0;
        data_n   = ram_data;
        addr_n   = sram_addr;
        dq_out_n = sram_dq_out;
        dq_oe_n  = sram_dq_oe;
        oe_n     = sram_oe;
        we_n     = 1'b0;
        beat_end = (cnt == LAST);

        case (state)
            IDLE: begin
                if (ram_read || ram_write) begin
                    cack_n = 1'b1;
                    busy_n = 1'b1;
                    cnt_n  = '0;
                    addr_n = {ram_addr, 1'b0};
                    if (ram_read) begin
                        state_n = RD_LO;
                        oe_n    = 1'b1;
                        dq_oe_n = 1'b0;
                    end else begin
                        state_n  = WR_LO;
                        dq_oe_n  = 1'b1;
                        dq_out_n = ram_wdata[15:0];
                        hold_n   = ram_wdata[31:16];
                    end
                end
            end
            RD_LO: begin
                if (beat_end) begin
                    hold_n    = sram_dq_in;
                    addr_n[0] = 1'b1;
                    cnt_n     = '0;
                    state_n   = RD_HI;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RD_HI: begin
                if (beat_end) begin
                    data_n  = {sram_dq_in, hold};
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                    oe_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            // First cycle of a write beat is setup; the strobe covers the remaining ones.
            WR_LO: begin
                if (beat_end) begin
                    addr_n[0] = 1'b1;
                    dq_out_n  = hold;
                    cnt_n     = '0;
                    state_n   = WR_HI;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    we_n  = 1'b1;
                end
            end
            WR_HI: begin
                if (beat_end) begin
                    dq_oe_n = 1'b0;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    we_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of single transactions on a W=1 instance plus
// hand sequences for retry streaming, mid-write reset and a W=3 instance.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // W=1 instance
    logic        read, write, cack, busy, ready, dq_oe, oe, we;
    logic [15:0] addr, dq_out, dq_in;
    logic [31:0] wdata, data;
    logic [16:0] saddr;

    // W=3 instance
    logic        s3_read, s3_write, s3_cack, s3_busy, s3_ready, s3_dq_oe, s3_oe, s3_we;
    logic [15:0] s3_addr, s3_dq_out, s3_dq_in;
    logic [31:0] s3_wdata, s3_data;
    logic [16:0] s3_saddr;

    mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .ram_read(read), .ram_write(write), .ram_addr(addr),
        .ram_wdata(wdata), .ram_cack(cack), .ram_busy(busy), .ram_data_ready(ready),
        .ram_data(data), .sram_addr(saddr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
        .sram_dq_oe(dq_oe), .sram_oe(oe), .sram_we(we)
    );

    mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .ram_read(s3_read), .ram_write(s3_write), .ram_addr(s3_addr),
        .ram_wdata(s3_wdata), .ram_cack(s3_cack), .ram_busy(s3_busy), .ram_data_ready(s3_ready),
        .ram_data(s3_data), .sram_addr(s3_saddr), .sram_dq_out(s3_dq_out), .sram_dq_in(s3_dq_in),
        .sram_dq_oe(s3_dq_oe), .sram_oe(s3_oe), .sram_we(s3_we)
    );

    // SRAM model for the W=1 instance: write on any edge with the strobe high.
    logic [15:0] mem [0:131071];
    always @(posedge clk) if (we) mem[saddr] <= dq_out;
    assign dq_in = oe ? mem[saddr] : 16'hDEAD;

    function automatic logic [15:0] s3_model(input logic [16:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction
    assign s3_dq_in = s3_oe ? s3_model(s3_saddr) : 16'hDEAD;

    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the W=1 instance; k counts edges since the accepting edge.
    task automatic run_txn(input logic rd_i, input logic wr_i, input logic [15:0] a,
                           input logic [31:0] wd, output logic acked, output int lat,
                           output int busy_cnt, output int stray, output logic [16:0] alo,
                           output logic [16:0] ahi, output logic [31:0] we_pat);
        @(negedge clk);
        read = rd_i; write = wr_i; addr = a; wdata = wd;
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cack) begin
                acked = 1'b1;
                break;
            end
        end
        read = 1'b0; write = 1'b0; addr = ~a; wdata = ~wd;
        lat = -1; busy_cnt = 0; stray = 0; we_pat = '0; alo = saddr; ahi = '0;
        if (acked) begin
            for (int k = 0; k < 40; k++) begin
                if (k > 0) @(negedge clk);
                if (ready) begin
                    lat = k;
                    if (cack) stray++;
                    break;
                end
                if (k > 0 && cack) stray++;
                if (k > 0 && busy) busy_cnt++;
                if (k < 32) we_pat[k] = we;
                ahi = saddr;
            end
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [16:0] exp_alo;
        logic [16:0] exp_ahi;
        logic [31:0] exp_we;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic        acked;
        int          lat, busy_cnt, stray;
        logic [16:0] alo, ahi;
        logic [31:0] we_pat;
        logic [31:0] expq [$];
        logic [31:0] exp_w;
        int          n_done, last_ready, s_stray;
        logic        inflight, oe_all;
        logic [16:0] a3_lo, a3_hi;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 32'h0000_0000, 32'hBEEF1234, 17'h00020, 17'h00021, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 32'hA5A55A5A, 32'hBEEF1234, 17'h1FFFE, 17'h1FFFF, 32'hA};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 32'hA5A55A5A, 17'h1FFFE, 17'h1FFFF, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 16'h1234, 32'h00C0FFEE, 32'hA5A55A5A, 17'h02468, 17'h02469, 32'hA};
        vecs[4] = '{1'b1, 1'b0, 16'h1234, 32'h0000_0000, 32'h00C0FFEE, 17'h02468, 17'h02469, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 32'hDEADDEAD, 32'hBEEF1234, 17'h00020, 17'h00021, 32'h0};

        mem[17'h00020] = 16'h1234;
        mem[17'h00021] = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            mem[17'(2 * (16'h0100 + i))]     = 16'(16'h1100 + i);
            mem[17'(2 * (16'h0100 + i) + 1)] = 16'(16'h2200 + i);
        end

        rst = 1'b0;
        read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        s3_read = 1'b0; s3_write = 1'b0; s3_addr = '0; s3_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'(0), cack, busy, ready, dq_oe, oe, we, 2'b00}, 32'h0);
        check("reset_data", data, 32'h0);
        check("reset_saddr", 32'(saddr), 32'h0);
        rst = 1'b1;

        // Table of single transactions
        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                    acked, lat, busy_cnt, stray, alo, ahi, we_pat);
            check($sformatf("v%0d_cack", v), 32'(acked), 32'h1);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'd4);
            check($sformatf("v%0d_busy", v), 32'(busy_cnt), 32'd3);
            check($sformatf("v%0d_stray_cack", v), 32'(stray), 32'd0);
            check($sformatf("v%0d_data", v), data, vecs[v].exp_data);
            check($sformatf("v%0d_addr_lo", v), 32'(alo), 32'(vecs[v].exp_alo));
            check($sformatf("v%0d_addr_hi", v), 32'(ahi), 32'(vecs[v].exp_ahi));
            check($sformatf("v%0d_we_pattern", v), we_pat, vecs[v].exp_we);
        end
        check("mem_1fffe", 32'(mem[17'h1FFFE]), 32'h5A5A);
        check("mem_1ffff", 32'(mem[17'h1FFFF]), 32'hA5A5);
        check("mem_02468", 32'(mem[17'h02468]), 32'hFFEE);
        check("both_no_write", {mem[17'h00021], mem[17'h00020]}, 32'hBEEF1234);

        // Fetch-style retry: read held high, address changing every cycle
        @(negedge clk);
        read = 1'b1; addr = 16'h0100;
        n_done = 0; last_ready = -10; s_stray = 0; inflight = 1'b0;
        for (int cyc = 0; cyc < 80 && n_done < 3; cyc++) begin
            @(negedge clk);
            if (cack) begin
                if (inflight) s_stray++;
                else begin
                    inflight = 1'b1;
                    expq.push_back({16'(16'h2200 + (addr - 16'h0100)), 16'(16'h1100 + (addr - 16'h0100))});
                    if (n_done > 0) check("stream_gap", 32'(cyc - last_ready), 32'd1);
                end
            end
            if (inflight && busy == 1'b0 && !ready) s_stray++;
            if (ready) begin
                exp_w = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                check("stream_data", data, exp_w);
                last_ready = cyc;
                inflight = 1'b0;
                n_done++;
            end
            addr = 16'(16'h0100 + ((cyc + 1) % 5));
        end
        read = 1'b0;
        check("stream_done", 32'(n_done), 32'd3);
        check("stream_stray", 32'(s_stray), 32'd0);

        // Reset in the middle of a write strobe
        @(negedge clk);
        @(negedge clk);
        write = 1'b1; addr = 16'h0300; wdata = 32'h11112222;
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cack) begin
                acked = 1'b1;
                break;
            end
        end
        write = 1'b0;
        check("rst_wr_cack", 32'(acked), 32'h1);
        @(negedge clk);
        check("rst_we_before", 32'(we), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort", {28'(0), we, busy, ready, dq_oe}, 32'h0);
        rst = 1'b1;
        run_txn(1'b1, 1'b0, 16'h0010, 32'h0, acked, lat, busy_cnt, stray, alo, ahi, we_pat);
        check("post_rst_cack", 32'(acked), 32'h1);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_data", data, 32'hBEEF1234);

        // W=3 instance: 4-clock beats, 8-clock latency
        @(negedge clk);
        s3_read = 1'b1; s3_addr = 16'h0777;
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s3_cack) begin
                acked = 1'b1;
                break;
            end
        end
        s3_read = 1'b0; s3_addr = 16'h0000;
        lat = -1; oe_all = 1'b1; a3_lo = '0; a3_hi = '0;
        if (acked) begin
            for (int k = 0; k < 40; k++) begin
                if (k > 0) @(negedge clk);
                if (s3_ready) begin
                    lat = k;
                    break;
                end
                oe_all = oe_all & s3_oe;
                if (k == 3) a3_lo = s3_saddr;
                if (k == 4) a3_hi = s3_saddr;
            end
        end
        check("w3_cack", 32'(acked), 32'h1);
        check("w3_latency", 32'(lat), 32'd8);
        check("w3_oe_held", 32'(oe_all), 32'h1);
        check("w3_addr_lo_end", 32'(a3_lo), 32'h00EEE);
        check("w3_addr_hi_start", 32'(a3_hi), 32'h00EEF);
        check("w3_data", s3_data, {s3_model(17'h00EEF), s3_model(17'h00EEE)});
        check("w3_oe_released", 32'(s3_oe), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's RAM request interface. It accepts read/write commands from the fetch unit or memory stage (ram_read/ram_write, 16-bit word address), acknowledges them with ram_cack, and signals busy while it runs. It performs two 16-bit beats on an external asynchronous SRAM for each 32-bit word, then returns the word with a one-cycle ram_data_ready pulse.

Parameters:
WAIT_CYCLES, 1, SRAM wait cycles per beat (legal range >= 1); each beat lasts WAIT_CYCLES+1 clocks.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-low
ram_read  in  1  read request (level; requester holds/retries until cack)
ram_write  in  1  write request (level)
ram_addr  in  16  word address, sampled at acceptance
ram_wdata  in  32  write data, sampled at acceptance
ram_cack  out  1  command accepted, one-cycle pulse
ram_busy  out  1  transaction in progress
ram_data_ready  out  1  read data valid / write complete, one-cycle pulse
ram_data  out  32  read word {hi,lo}; holds until next read completes
sram_addr  out  17  halfword address {word_addr, beat}
sram_dq_out  out  16  write halfword
sram_dq_in  in  16  read halfword
sram_dq_oe  out  1  drive data bus (writes only)
sram_oe  out  1  output enable (reads)
sram_we  out  1  write strobe

Behaviour:
- Reset (rst=0 at posedge): state IDLE; ram_cack=0, ram_busy=0, ram_data_ready=0, ram_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_oe=0, sram_we=0, wait counter=0. Reset mid-transaction aborts it with no data_ready, and sram_we drops on that edge.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI.
- IDLE: a request sampled at edge N latches ram_addr and ram_wdata. After edge N, ram_cack=1 for exactly one cycle and ram_busy=1.
  - ram_read -> RD_LO.
  - ram_write -> WR_LO.
  - Both asserted -> read wins; the write is not acked.
- Requests arriving outside IDLE get no cack. The requester must retry.
- Read beat: sram_addr={addr,0} in RD_LO and {addr,1} in RD_HI; sram_oe=1 and sram_dq_oe=0 throughout.
  - sram_dq_in is captured on the last edge of each beat, edge N+(W+1) for lo and edge N+2(W+1) for hi.
  - After the hi capture edge: ram_data={hi,lo}, ram_data_ready=1 for one cycle, ram_busy=0, sram_oe=0, state IDLE.
  - Read latency, accept edge to data_ready: 2(W+1) clocks (4 for W=1).
- Write beat: sram_dq_oe=1 and sram_dq_out = the halfword (lo = wdata[15:0], hi = wdata[31:16]).
  - First cycle of each beat is setup with sram_we=0; sram_we=1 for the remaining W cycles.
  - Address and data are stable for the whole beat.
  - After the final WR_HI edge: sram_we=0, sram_dq_oe=0, ram_data_ready=1 for one cycle, ram_busy=0, ram_data unchanged, state IDLE.
- The completion edge does not accept a new request; earliest next acceptance is the following edge, so back-to-back transactions have one IDLE cycle between them.
- ram_cack and ram_data_ready are never both 1 in the same cycle.
- ram_busy is 1 exactly from the cycle after acceptance through the cycle before data_ready.
- Address is 16-bit word; no wrap handling needed (address 0xFFFF maps to sram_addr 0x1FFFE/0x1FFFF).
- Changes on ram_addr/ram_wdata after acceptance have no effect.

Test Plan:
1. W=1, SRAM model word 0x0010 = {0xBEEF,0x1234}; pulse ram_read with addr=0x0010 -> cack 1 cycle after accept; busy 3 cycles; data_ready 4 clocks after accept with ram_data=0xBEEF1234; sram_addr 0x00020 then 0x00021.
2. Write addr=0xFFFF, wdata=0xA5A55A5A -> sram beats to 0x1FFFE=0x5A5A and 0x1FFFF=0xA5A5; each beat shows one setup cycle then one cycle of sram_we=1; data_ready pulse; read back returns 0xA5A55A5A.
3. Hold ram_read high continuously with changing addr (fetch retry style) -> one cack per transaction; no cack while busy; one IDLE gap between transactions; each returned word matches the address latched at its cack.
4. ram_read and ram_write asserted together -> a read is performed, no SRAM write occurs, and ram_data is updated.
5. Assert rst=0 during WR_LO with sram_we=1 -> next edge: sram_we=0, busy=0, no data_ready; after release, a fresh read completes normally.
6. WAIT_CYCLES=3, read -> each beat is 4 clocks, data_ready 8 clocks after accept, and sram_oe stays high the whole time.
